// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, capture FSM encoding and address helper.
// Also consumed by the display generator so both sides agree on the raster.
package vga_timing_pkg;

  localparam int H_ACT_START_D = 144;
  localparam int H_ACTIVE_D    = 640;
  localparam int H_LINE_D      = 800;
  localparam int V_ACT_START_D = 35;
  localparam int V_ACTIVE_D    = 480;
  localparam int V_FRAME_D     = 525;

  localparam int HPOS_W  = 11;
  localparam int VPOS_W  = 10;
  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  // Linear frame-buffer address of a raster position, wrapped to ADDR_W bits.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [VPOS_W-1:0] v,
                                                 input logic [HPOS_W-1:0] h,
                                                 input int v0, input int h0,
                                                 input int hact);
    logic [ADDR_W-1:0] dv, dh;
    dv = ADDR_W'(v) - ADDR_W'(v0);
    dh = ADDR_W'(h) - ADDR_W'(h0);
    return dv * ADDR_W'(hact) + dh;
  endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Registers hs/vs, detects their falling edges and tracks the raster position
// of the current sample (h_pos/v_pos already reflect this cycle's edges).
module vga_sync_tracker
  import vga_timing_pkg::*;
(
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              hs_i,
  input  logic              vs_i,
  output logic              hs_fall_o,
  output logic              vs_fall_o,
  output logic [HPOS_W-1:0] h_pos_o,
  output logic [VPOS_W-1:0] v_pos_o
);

  logic              hs_q, vs_q;
  logic [HPOS_W-1:0] h_pos_q, h_pos_d;
  logic [VPOS_W-1:0] v_pos_q, v_pos_d;

  assign hs_fall_o = ~hs_i & hs_q;
  assign vs_fall_o = ~vs_i & vs_q;

  always_comb begin
    h_pos_d = (h_pos_q == '1) ? h_pos_q : h_pos_q + HPOS_W'(1);
    if (hs_fall_o) h_pos_d = '0;
    v_pos_d = v_pos_q;
    if (hs_fall_o && (v_pos_q != '1)) v_pos_d = v_pos_q + VPOS_W'(1);
    if (vs_fall_o) v_pos_d = '0;
  end

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      h_pos_q <= '0;
      v_pos_q <= '0;
    end else begin
      hs_q    <= hs_i;
      vs_q    <= vs_i;
      h_pos_q <= h_pos_d;
      v_pos_q <= v_pos_d;
    end
  end

  assign h_pos_o = h_pos_d;
  assign v_pos_o = v_pos_d;

endmodule

// File: rtl/vga_frame_capture.sv
// Captures one VGA frame into a frame buffer per capture_req, starting at the next vs fall.
// Define VGA_CAP_CHECK_EN to build the sticky line/frame timing checker behind frame_err.
module vga_frame_capture
  import vga_timing_pkg::*;
#(
  parameter int H_ACT_START = H_ACT_START_D,
  parameter int H_ACTIVE    = H_ACTIVE_D,
  parameter int V_ACT_START = V_ACT_START_D,
  parameter int V_ACTIVE    = V_ACTIVE_D,
  parameter int H_LINE      = H_LINE_D,
  parameter int V_FRAME     = V_FRAME_D
) (
  input  logic               vga_clk,
  input  logic               rst,
  input  logic               hs,
  input  logic               vs,
  input  logic [COLOR_W-1:0] vga_color,
  input  logic               capture_req,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic               frame_err
);

  localparam logic [HPOS_W-1:0] H_LO   = HPOS_W'(H_ACT_START);
  localparam logic [HPOS_W-1:0] H_HI   = HPOS_W'(H_ACT_START + H_ACTIVE);
  localparam logic [HPOS_W-1:0] H_LAST = HPOS_W'(H_ACT_START + H_ACTIVE - 1);
  localparam logic [VPOS_W-1:0] V_LO   = VPOS_W'(V_ACT_START);
  localparam logic [VPOS_W-1:0] V_HI   = VPOS_W'(V_ACT_START + V_ACTIVE);
  localparam logic [VPOS_W-1:0] V_LAST = VPOS_W'(V_ACT_START + V_ACTIVE - 1);

  logic              hs_fall, vs_fall, active, last_pix;
  logic [HPOS_W-1:0] h_pos;
  logic [VPOS_W-1:0] v_pos;

  cap_state_e         state_q;
  logic               wr_en_q, busy_q, done_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [COLOR_W-1:0] wr_data_q;

  vga_sync_tracker u_trk (
    .vga_clk   (vga_clk),
    .rst       (rst),
    .hs_i      (hs),
    .vs_i      (vs),
    .hs_fall_o (hs_fall),
    .vs_fall_o (vs_fall),
    .h_pos_o   (h_pos),
    .v_pos_o   (v_pos)
  );

  assign active   = (h_pos >= H_LO) && (h_pos < H_HI) && (v_pos >= V_LO) && (v_pos < V_HI);
  assign last_pix = active && (h_pos == H_LAST) && (v_pos == V_LAST);

  // A vs fall while capturing ends the capture early; that sample is not written.
  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (capture_req) begin
          state_q <= WAIT_VS;
          busy_q  <= 1'b1;
        end
        WAIT_VS: if (vs_fall) state_q <= CAPTURE;
        CAPTURE: begin
          if (vs_fall) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end else if (active) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= pix_addr(v_pos, h_pos, V_ACT_START, H_ACT_START, H_ACTIVE);
            wr_data_q <= vga_color;
            if (last_pix) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef VGA_CAP_CHECK_EN
  localparam logic [HPOS_W:0] H_LINE_L  = (HPOS_W+1)'(H_LINE);
  localparam logic [VPOS_W:0] V_FRAME_L = (VPOS_W+1)'(V_FRAME);

  logic [HPOS_W-1:0] h_prev_q;
  logic [VPOS_W-1:0] v_prev_q;
  logic              h_seen_q, v_seen_q, err_q, err_set;

  // Lengths are only judged once a previous edge has been seen since reset.
  always_comb begin
    err_set = 1'b0;
    if (hs_fall && h_seen_q && (({1'b0, h_prev_q} + (HPOS_W+1)'(1)) != H_LINE_L)) err_set = 1'b1;
    if (vs_fall && v_seen_q && (({1'b0, v_prev_q} + (VPOS_W+1)'(1)) != V_FRAME_L)) err_set = 1'b1;
    if ((state_q == CAPTURE) && vs_fall) err_set = 1'b1;
  end

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      h_prev_q <= '0;
      v_prev_q <= '0;
      h_seen_q <= 1'b0;
      v_seen_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      h_prev_q <= h_pos;
      v_prev_q <= v_pos;
      if (hs_fall) h_seen_q <= 1'b1;
      if (vs_fall) v_seen_q <= 1'b1;
      if (err_set) err_q <= 1'b1;
      else if ((state_q == IDLE) && capture_req) err_q <= 1'b0;
    end
  end

  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// Scoreboard bench for vga_frame_capture on a shrunken raster (16x8 total, 8x4 active).
module tb_vga_frame_capture;

  localparam int HAS = 4, HACT = 8, VAS = 2, VACT = 4, HL = 16, VF = 8;
`ifdef VGA_CAP_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        vga_clk = 1'b0;
  logic        rst, hs, vs, capture_req;
  logic [11:0] vga_color;
  logic        wr_en, busy, done, frame_err;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;

  typedef struct {
    logic [18:0] addr;
    logic [11:0] data;
  } wr_t;
  wr_t sb[$];

  int checks = 0, errors = 0;
  int cyc = 0, wr_cnt = 0, done_cnt = 0, last_wr_cyc = 0;
  bit chk_lat = 1'b0;
  int base_w, base_d;

  always #5 vga_clk = ~vga_clk;

  vga_frame_capture #(
    .H_ACT_START(HAS), .H_ACTIVE(HACT), .V_ACT_START(VAS), .V_ACTIVE(VACT),
    .H_LINE(HL), .V_FRAME(VF)
  ) u_dut (
    .vga_clk(vga_clk), .rst(rst), .hs(hs), .vs(vs), .vga_color(vga_color),
    .capture_req(capture_req), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .frame_err(frame_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected writes for active lines y=first..first+n-1: pixel = {v[3:0], h[7:0]}.
  task automatic push_lines(input int first, input int n);
    wr_t e;
    for (int y = first; y < first + n; y++)
      for (int x = 0; x < HACT; x++) begin
        e.addr = 19'(y * HACT + x);
        e.data = {4'(y + VAS), 8'(x + HAS)};
        sb.push_back(e);
      end
  endtask

  task automatic mid_reset();
    chk("rst_pre_wr_en", wr_en, 1);
    chk("rst_pre_addr", wr_addr, 10);
    rst = 1'b0;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_err", frame_err, 0);
    rst = 1'b1;
    sb.delete();
  endtask

  // One frame: hs low 2 cycles per line, vs low for line 0; -1 disables an option.
  task automatic run_frame(input int req_line, input int abort_line,
                           input int long_line, input int rst_line);
    int len;
    for (int v = 0; v < VF; v++) begin
      if (v == abort_line) return;
      len = (v == long_line) ? HL + 1 : HL;
      for (int h = 0; h < len; h++) begin
        @(posedge vga_clk); #1;
        hs          = (h < 2) ? 1'b0 : 1'b1;
        vs          = (v == 0) ? 1'b0 : 1'b1;
        vga_color   = {4'(v), 8'(h)};
        capture_req = (v == req_line) && (h == 5);
        if ((v == rst_line) && (h == 7)) mid_reset();
      end
    end
  endtask

  initial begin
    rst = 1'b0; hs = 1'b1; vs = 1'b1; vga_color = '0; capture_req = 1'b0;
    fork
      forever begin
        wr_t e;
        @(negedge vga_clk);
        cyc++;
        if (wr_en) begin
          wr_cnt++;
          last_wr_cyc = cyc;
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr=%0d data=%0h, none expected", wr_addr, wr_data);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", 32'(wr_addr), 32'(e.addr));
            chk("wr_data", 32'(wr_data), 32'(e.data));
          end
        end
        if (done) begin
          done_cnt++;
          if (chk_lat) chk("done_latency", cyc - last_wr_cyc, 1);
        end
      end
    join_none

    repeat (3) @(posedge vga_clk);
    #1;
    chk("reset_wr_en", wr_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", frame_err, 0);
    chk("reset_addr", wr_addr, 0);
    chk("reset_data", wr_data, 0);
    rst = 1'b1;
    repeat (2) @(posedge vga_clk);

    // full capture, request mid-frame
    chk_lat = 1'b1; base_w = wr_cnt; base_d = done_cnt;
    run_frame(3, -1, -1, -1);
    chk("t1_busy_wait", busy, 1);
    chk("t1_no_early_wr", wr_cnt - base_w, 0);
    push_lines(0, VACT);
    run_frame(-1, -1, -1, -1);
    chk("t1_writes", wr_cnt - base_w, HACT * VACT);
    chk("t1_done", done_cnt - base_d, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_err", frame_err, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // second request while capturing is ignored
    base_w = wr_cnt; base_d = done_cnt;
    run_frame(3, -1, -1, -1);
    push_lines(0, VACT);
    run_frame(3, -1, -1, -1);
    run_frame(-1, -1, -1, -1);
    chk("t2_writes", wr_cnt - base_w, HACT * VACT);
    chk("t2_done", done_cnt - base_d, 1);

    // early vs fall at v_pos=4 aborts after two active lines
    chk_lat = 1'b0; base_w = wr_cnt; base_d = done_cnt;
    run_frame(3, -1, -1, -1);
    push_lines(0, 2);
    run_frame(-1, 4, -1, -1);
    run_frame(-1, -1, -1, -1);
    chk("t3_writes", wr_cnt - base_w, 2 * HACT);
    chk("t3_done", done_cnt - base_d, 1);
    chk("t3_busy", busy, 0);
    chk("t3_err", frame_err, CHK);

    // new request clears the flag; one 17-cycle line sets it again
    chk_lat = 1'b1; base_w = wr_cnt; base_d = done_cnt;
    run_frame(3, -1, -1, -1);
    chk("t4_err_cleared", frame_err, 0);
    push_lines(0, VACT);
    run_frame(-1, -1, 3, -1);
    chk("t4_writes", wr_cnt - base_w, HACT * VACT);
    chk("t4_done", done_cnt - base_d, 1);
    chk("t4_err", frame_err, CHK);

    // reset while writing addr 10, then silence without a new request
    chk_lat = 1'b0; base_w = wr_cnt; base_d = done_cnt;
    run_frame(3, -1, -1, -1);
    push_lines(0, VACT);
    run_frame(-1, -1, -1, 3);
    run_frame(-1, -1, -1, -1);
    chk("t5_writes", wr_cnt - base_w, 10);
    chk("t5_done", done_cnt - base_d, 0);
    chk("t5_busy", busy, 0);

    // hs stuck high: position saturates, nothing written, still waiting
    base_w = wr_cnt;
    @(posedge vga_clk); #1;
    capture_req = 1'b1; hs = 1'b1; vs = 1'b1;
    @(posedge vga_clk); #1;
    capture_req = 1'b0;
    repeat (2100) @(posedge vga_clk);
    #1;
    chk("t6_busy", busy, 1);
    chk("t6_h_sat", 32'(u_dut.u_trk.h_pos_q), 2047);
    chk("t6_writes", wr_cnt - base_w, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
